// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit_if
//  Purpose  : Bundle of the fetch stage's pipeline-control, instruction-memory
//             and IF/ID signals. The slave modport is the fetch unit's view;
//             the master modport is the surrounding pipeline and memory.
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_unit_if;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc;
  logic        ifid_valid;
  logic        halted;

  modport slave (
    input  stall, flush, redirect, redirect_pc, imem_data,
    output imem_addr, ifid_instr, ifid_pc, ifid_valid, halted
  );

  modport master (
    output stall, flush, redirect, redirect_pc, imem_data,
    input  imem_addr, ifid_instr, ifid_pc, ifid_valid, halted
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch stage. Holds the PC, presents it to a
//             combinational instruction memory and captures the returned word
//             into the IF/ID register one cycle later.
//             Optional macro FETCH_HALT_DETECT_EN enables stopping fetch when
//             HALT_WORD is fetched; without it HALT_WORD is an ordinary word.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] HALT_WORD = 16'hF000
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.slave  bus
);

`ifdef FETCH_HALT_DETECT_EN
  localparam bit c_HALT_EN = 1'b1;
`else
  localparam bit c_HALT_EN = 1'b0;
`endif

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t      state_q;
  logic        halted_q;
  logic [15:0] pc_q,    pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] ipc_q,   ipc_d;
  logic        valid_q, valid_d;

  // Normal advance: redirect outranks stall, and a halted unit never advances.
  logic w_advance;
  logic w_halt_hit;
  assign w_advance  = !bus.redirect && !bus.stall && (state_q == ST_RUN);
  assign w_halt_hit = c_HALT_EN && w_advance && (bus.imem_data == HALT_WORD);

  // Next-state for PC and IF/ID following redirect > halt-hold > stall > advance.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    if (bus.redirect) begin
      pc_d    = bus.redirect_pc;
      valid_d = 1'b0;
    end else if (state_q == ST_HALT) begin
      valid_d = 1'b0;
    end else if (bus.stall) begin
      valid_d = valid_q & ~bus.flush;
    end else begin
      instr_d = bus.imem_data;
      ipc_d   = pc_q;
      valid_d = ~bus.flush;
      // The halt word is latched like any instruction but the PC parks on it.
      if (!w_halt_hit) begin
        pc_d = pc_q + 16'd1;
      end
    end
  end

  // PC and IF/ID registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= 16'h0000;
      ipc_q   <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
    end
  end

  // RUN/HALT controller; halted is a registered copy of the HALT state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (w_halt_hit) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end
        end
        ST_HALT: begin
          if (bus.redirect) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.ifid_instr = instr_q;
  assign bus.ifid_pc    = ipc_q;
  assign bus.ifid_valid = valid_q;
  assign bus.halted     = halted_q;

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, word address loaded into PC on reset.
REQ-002 SHALL have parameter HALT_WORD, default 16'hF000, instruction encoding treated as halt when FETCH_HALT_DETECT_EN is defined.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port stall  input  1  hold PC and IF/ID register.
REQ-006 SHALL have port flush  input  1  invalidate IF/ID register.
REQ-007 SHALL have port redirect  input  1  load PC from redirect_pc (branch/jump taken).
REQ-008 SHALL have port redirect_pc  input  16  redirect target word address.
REQ-009 SHALL have port imem_addr  output  16  word address to instruction memory; equals PC.
REQ-010 SHALL have port imem_data  input  16  instruction word returned combinationally by instruction memory for imem_addr.
REQ-011 SHALL have port ifid_instr  output  16  registered instruction.
REQ-012 SHALL have port ifid_pc  output  16  registered address of ifid_instr.
REQ-013 SHALL have port ifid_valid  output  1  ifid_instr holds a real instruction.
REQ-014 SHALL have port halted  output  1  fetch stopped on halt word.

Function
REQ-015 SHALL drive imem_addr combinationally from the PC register, zero-latency.
REQ-016 SHALL treat imem_data as valid in the same cycle as imem_addr; one-cycle fetch-to-IF/ID latency.
REQ-017 SHALL use per-edge priority: rst > redirect > stall > normal advance.
REQ-018 SHALL, on redirect, load PC<=redirect_pc and ifid_valid<=0; ifid_instr/ifid_pc are don't-care; this applies even with stall=1.
REQ-019 SHALL, on advance (no redirect, no stall, state RUN), load ifid_instr<=imem_data, ifid_pc<=PC, ifid_valid<=~flush, PC<=PC+1.
REQ-020 SHALL, on stall without redirect, hold PC, ifid_instr and ifid_pc; ifid_valid<=ifid_valid & ~flush.
REQ-021 SHALL increment PC modulo 2^16: 16'hFFFF advances to 16'h0000 with no flag.
REQ-022 SHALL have states RUN and HALT; HALT is reachable only when FETCH_HALT_DETECT_EN is defined.
REQ-023 SHALL, in RUN on advance with imem_data==HALT_WORD, latch the halt word into IF/ID as a normal advance (valid unless flush), hold PC, and go to HALT.
REQ-024 SHALL, in HALT without redirect, hold PC, set ifid_valid<=0 and ignore stall and flush.
REQ-025 SHALL, in HALT with redirect, apply REQ-018 and return to RUN.
REQ-026 SHALL drive halted=1 exactly while in HALT, registered.
REQ-027 SHALL NOT detect halt when stall=1 or redirect=1 in that cycle.

Reset
REQ-028 SHALL, with rst=1 at a clock edge, set PC<=RESET_PC, ifid_instr<=16'h0000, ifid_pc<=16'h0000, ifid_valid<=0, state<=RUN, halted<=0, overriding all other inputs.
REQ-029 SHALL abandon any in-flight redirect, stall or halt when reset is asserted mid-operation; the first fetch after rst deasserts is from RESET_PC.

Configuration
REQ-030 SHALL, with macro FETCH_HALT_DETECT_EN defined, implement halt detection per REQ-022..REQ-027.
REQ-031 SHALL, without FETCH_HALT_DETECT_EN, keep state fixed in RUN, tie halted to 0, and fetch HALT_WORD as an ordinary instruction.

Verification
REQ-032 SHALL cover reset then 3 free-run cycles with memory[0..2]=1111,2222,3333 -> imem_addr 0,1,2,3; ifid_instr 1111,2222,3333; ifid_pc 0,1,2; ifid_valid=1.
REQ-033 SHALL cover stall=1 for 2 cycles at PC=5 -> imem_addr stays 5; IF/ID unchanged; resumes at 5 after release.
REQ-034 SHALL cover redirect=1, redirect_pc=16'h0040, stall=1, flush=0 in the same cycle -> next imem_addr=0040, ifid_valid=0.
REQ-035 SHALL cover PC=FFFF advancing -> imem_addr=0000, ifid_pc=FFFF.
REQ-036 SHALL cover the macro defined with memory[7]=F000 -> ifid_instr=F000 valid; halted=1; imem_addr stays 7; ifid_valid=0 next cycle; redirect to 0010 -> RUN, imem_addr=0010. With the macro undefined -> halted=0 and imem_addr advances to 8.
REQ-037 SHALL cover rst=1 asserted while in HALT with PC=7 -> halted=0, imem_addr=RESET_PC, ifid_valid=0.
